wddl_dr_decoder: RTL and testbench
==================================

WDDL_DR_DECODER -- requirements
Module: wddl_dr_decoder

Interface
REQ-001 Parameter W, default 8, dual-rail bus width in bits.
REQ-002 Parameter TIMEOUT, default 16, maximum number of clock edges spent in WAIT_EVAL before a timeout error; legal range 3..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 dr_t  input  W  WDDL true rails; precharge value 0.
REQ-006 dr_f  input  W  WDDL false rails; precharge value 0.
REQ-007 out_ready  input  1  downstream accepts data when high with out_valid.
REQ-008 data  output  W  decoded single-rail word.
REQ-009 out_valid  output  1  data valid, held until accepted.
REQ-010 err_invalid  output  1  one-cycle pulse: an illegal 11 rail pair was seen during evaluation.
REQ-011 err_timeout  output  1  one-cycle pulse: evaluation did not complete within TIMEOUT.
REQ-012 err_count  output  8  saturating count of error events.

Function
REQ-013 Rails SHALL be registered every edge into t_q/f_q; a second register SHALL hold the previous t_q (t_p); all decisions use registered values only.
REQ-014 Pair classes: per bit, 00 = precharged, 10/01 = evaluated, 11 = invalid; PRE = all bits 00; EVAL = all bits 10/01; INV = any bit 11.
REQ-015 FSM states: WAIT_PRE, WAIT_EVAL, HOLD; reset state WAIT_PRE.
REQ-016 WAIT_PRE: on PRE -> WAIT_EVAL with timer cleared to 0; otherwise stay; INV in this state is ignored.
REQ-017 WAIT_EVAL: timer increments by 1 each edge.
REQ-018 WAIT_EVAL, priority 1: on INV, pulse err_invalid, increment err_count, and go to WAIT_PRE.
REQ-019 WAIT_EVAL, priority 2: on EVAL with t_q == t_p and the previous sample also EVAL (stable for two samples), capture data <= t_q, set out_valid, and go to HOLD.
REQ-020 WAIT_EVAL, priority 3: on the TIMEOUT-th edge in WAIT_EVAL without capture, pulse err_timeout, increment err_count, and go to WAIT_PRE.
REQ-021 When INV and timeout coincide, only err_invalid SHALL fire and err_count SHALL increment exactly once.
REQ-022 Latency: if the rails are complete and constant at sampling edges k and k+1, out_valid SHALL be high after edge k+2.
REQ-023 HOLD: data and out_valid SHALL remain stable until out_valid && out_ready.
REQ-024 On the accepting edge, out_valid clears and the FSM goes to WAIT_PRE; a new capture requires an intervening PRE.
REQ-025 Rail activity during HOLD SHALL be ignored: no errors and no data change.
REQ-026 err_count SHALL saturate at 255 and never wrap.
REQ-027 Error pulses SHALL be high for exactly one cycle per event.
REQ-028 The block SHALL never drive out_valid and an error pulse in the same cycle.

Reset
REQ-029 While rst is high, asynchronously: state = WAIT_PRE, t_q/f_q/t_p = 0, timer = 0, data = 0, out_valid = 0, err_invalid = 0, err_timeout = 0, err_count = 0.
REQ-030 Reset asserted mid-operation (including in HOLD) SHALL discard the pending word.
REQ-031 After rst deasserts, the block SHALL require a fresh PRE before any capture.

Verification
REQ-032 W=8, out_ready=1: rails 00 for 2 cycles, then dr_t=0xA5/dr_f=0x5A held for 3 cycles -> data=0xA5 with out_valid high for 1 cycle, 2 edges after the first complete sample, no errors.
REQ-033 out_ready=0 for 5 cycles after capture of 0x3C while rails change to 0x00/0xFF -> data stays 0x3C, out_valid stays high; on out_ready=1, accepted in 1 edge.
REQ-034 After PRE, dr_t=0x01/dr_f=0x03 (bit0 = 11) -> one err_invalid pulse, err_count=1, no out_valid, FSM waits for PRE.
REQ-035 After PRE, rails stuck at partial 0x0F/0x00 -> err_timeout pulse exactly on the 16th WAIT_EVAL edge, err_count increments by 1.
REQ-036 260 consecutive invalid events -> err_count=255 and held there; rst pulse mid-HOLD -> all outputs 0, err_count=0.
REQ-037 Rails change 0x11 -> 0x22 on consecutive complete samples -> no capture until two equal samples; capture data=0x22.

Source files
------------

// File: rtl/wddl_dr_decoder.sv
// Dual-rail (WDDL) to single-rail decoder: waits for a precharge wave, then captures
// the first complete word seen stable on two consecutive samples, with error reporting.
module wddl_dr_decoder #(
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] dr_t,
  input  logic [W-1:0] dr_f,
  input  logic         out_ready,
  output logic [W-1:0] data,
  output logic         out_valid,
  output logic         err_invalid,
  output logic         err_timeout,
  output logic [7:0]   err_count
);

  typedef enum logic [1:0] {WAIT_PRE, WAIT_EVAL, HOLD} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  logic [W-1:0] t_q;
  logic [W-1:0] f_q;
  logic [W-1:0] t_p;
  logic         prev_eval;
  logic         t_valid;
  logic [7:0]   timer;

  logic         is_pre;
  logic         is_inv;
  logic         is_eval;
  logic         stable;
  logic [7:0]   count_next;

  // t_valid keeps the reset value of t_q from being mistaken for a sampled precharge
  always_comb begin
    is_pre     = t_valid && ((t_q | f_q) == '0);
    is_inv     = |(t_q & f_q);
    is_eval    = &(t_q ^ f_q);
    stable     = is_eval && prev_eval && (t_q == t_p);
    count_next = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q       <= '0;
      f_q       <= '0;
      t_p       <= '0;
      prev_eval <= 1'b0;
      t_valid   <= 1'b0;
    end else begin
      t_q       <= dr_t;
      f_q       <= dr_f;
      t_p       <= t_q;
      prev_eval <= is_eval;
      t_valid   <= 1'b1;
    end
  end

  // Invalid beats capture, capture beats timeout; only one error event per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_PRE;
      timer       <= '0;
      data        <= '0;
      out_valid   <= 1'b0;
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        WAIT_PRE: begin
          if (is_pre) begin
            state <= WAIT_EVAL;
            timer <= '0;
          end
        end
        WAIT_EVAL: begin
          timer <= timer + 8'd1;
          if (is_inv) begin
            err_invalid <= 1'b1;
            err_count   <= count_next;
            state       <= WAIT_PRE;
          end else if (stable) begin
            data      <= t_q;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (timer == TIMER_LAST) begin
            err_timeout <= 1'b1;
            err_count   <= count_next;
            state       <= WAIT_PRE;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= WAIT_PRE;
          end
        end
        default: state <= WAIT_PRE;
      endcase
    end
  end

endmodule

// File: tb/tb_wddl_dr_decoder.sv
// Directed bench for wddl_dr_decoder: captured words go through a queue scoreboard,
// error pulses and the counter are checked at fixed points of the sequence.
module tb_wddl_dr_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] dr_t;
  logic [W-1:0] dr_f;
  logic         out_ready;
  logic [W-1:0] data;
  logic         out_valid;
  logic         err_invalid;
  logic         err_timeout;
  logic [7:0]   err_count;

  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [7:0]   exp_cnt;

  wddl_dr_decoder #(.W(W), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .dr_t(dr_t),
    .dr_f(dr_f),
    .out_ready(out_ready),
    .data(data),
    .out_valid(out_valid),
    .err_invalid(err_invalid),
    .err_timeout(err_timeout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A word is consumed when valid and ready are both high just before the edge
  task automatic tick();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", 32'(out_valid), 32'd0);
      else check("sb_data", 32'(data), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    check("valid_err_exclusive", 32'(out_valid & (err_invalid | err_timeout)), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [W-1:0] t, input logic [W-1:0] f, input int n);
    dr_t = t;
    dr_f = f;
    repeat (n) tick();
  endtask

  task automatic check_output(input string tag, input logic ev, input logic ei,
                              input logic et, input logic [7:0] ec);
    check({tag, "_valid"}, 32'(out_valid), 32'(ev));
    check({tag, "_err_invalid"}, 32'(err_invalid), 32'(ei));
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'(et));
    check({tag, "_err_count"}, 32'(err_count), 32'(ec));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    dr_t = '0;
    dr_f = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset_data", 32'(data), 32'd0);
    rst = 1'b0;

    $display("[TB] basic capture of 0xA5");
    apply_stimulus(8'h00, 8'h00, 2);
    check_output("t1_pre", 1'b0, 1'b0, 1'b0, 8'd0);
    exp_q.push_back(8'hA5);
    apply_stimulus(8'hA5, 8'h5A, 2);
    check_output("t1_latency", 1'b0, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'hA5, 8'h5A, 1);
    check_output("t1_capture", 1'b1, 1'b0, 1'b0, 8'd0);
    check("t1_data", 32'(data), 32'hA5);
    apply_stimulus(8'h00, 8'h00, 1);
    check_output("t1_accepted", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] backpressure while holding 0x3C");
    out_ready = 1'b0;
    apply_stimulus(8'h00, 8'h00, 2);
    exp_q.push_back(8'h3C);
    apply_stimulus(8'h3C, 8'hC3, 2);
    check_output("t2_latency", 1'b0, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h3C, 8'hC3, 1);
    check_output("t2_capture", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) apply_stimulus(8'hFF, 8'hFF, 1);
      else apply_stimulus(8'h00, 8'hFF, 1);
      check_output("t2_hold", 1'b1, 1'b0, 1'b0, 8'd0);
      check("t2_hold_data", 32'(data), 32'h3C);
    end
    out_ready = 1'b1;
    apply_stimulus(8'h00, 8'hFF, 1);
    check_output("t2_accepted", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] invalid rail pair during evaluation");
    apply_stimulus(8'h00, 8'h00, 2);
    apply_stimulus(8'h01, 8'h03, 1);
    check_output("t3_sampled", 1'b0, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h01, 8'h03, 1);
    check_output("t3_pulse", 1'b0, 1'b1, 1'b0, 8'd1);
    apply_stimulus(8'h01, 8'h03, 1);
    check_output("t3_ignored", 1'b0, 1'b0, 1'b0, 8'd1);

    $display("[TB] timeout on partial word");
    apply_stimulus(8'h00, 8'h00, 2);
    for (int i = 1; i <= 15; i++) begin
      apply_stimulus(8'h0F, 8'h00, 1);
      check_output("t4_waiting", 1'b0, 1'b0, 1'b0, 8'd1);
    end
    apply_stimulus(8'h0F, 8'h00, 1);
    check_output("t4_timeout", 1'b0, 1'b0, 1'b1, 8'd2);
    apply_stimulus(8'h0F, 8'h00, 1);
    check_output("t4_after", 1'b0, 1'b0, 1'b0, 8'd2);

    $display("[TB] invalid coinciding with timeout");
    apply_stimulus(8'h00, 8'h00, 2);
    apply_stimulus(8'h0F, 8'h00, 14);
    apply_stimulus(8'h01, 8'h03, 1);
    check_output("t4b_edge15", 1'b0, 1'b0, 1'b0, 8'd2);
    apply_stimulus(8'h01, 8'h03, 1);
    check_output("t4b_edge16", 1'b0, 1'b1, 1'b0, 8'd3);
    apply_stimulus(8'h01, 8'h03, 1);
    check_output("t4b_after", 1'b0, 1'b0, 1'b0, 8'd3);

    $display("[TB] changing word needs two equal samples");
    apply_stimulus(8'h00, 8'h00, 2);
    exp_q.push_back(8'h22);
    apply_stimulus(8'h11, 8'hEE, 1);
    apply_stimulus(8'h22, 8'hDD, 1);
    check_output("t5_first", 1'b0, 1'b0, 1'b0, 8'd3);
    apply_stimulus(8'h22, 8'hDD, 1);
    check_output("t5_second", 1'b0, 1'b0, 1'b0, 8'd3);
    apply_stimulus(8'h22, 8'hDD, 1);
    check_output("t5_capture", 1'b1, 1'b0, 1'b0, 8'd3);
    apply_stimulus(8'h00, 8'h00, 1);
    check("t5_accepted", 32'(out_valid), 32'd0);

    $display("[TB] error counter saturation");
    exp_cnt = 8'd3;
    for (int i = 0; i < 260; i++) begin
      apply_stimulus(8'h01, 8'h03, 1);
      check("t6_no_pulse", 32'(err_invalid), 32'd0);
      apply_stimulus(8'h00, 8'h00, 1);
      exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
      check("t6_pulse", 32'(err_invalid), 32'd1);
      check("t6_count", 32'(err_count), 32'(exp_cnt));
    end
    check("t6_saturated", 32'(err_count), 32'd255);

    $display("[TB] reset while holding a word");
    out_ready = 1'b0;
    apply_stimulus(8'h5A, 8'hA5, 2);
    check("t7_latency", 32'(out_valid), 32'd0);
    apply_stimulus(8'h5A, 8'hA5, 1);
    check("t7_capture", 32'(out_valid), 32'd1);
    check("t7_data", 32'(data), 32'h5A);
    #2;
    rst = 1'b1;
    #1;
    check_output("t7_reset", 1'b0, 1'b0, 1'b0, 8'd0);
    check("t7_reset_data", 32'(data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h5A, 8'hA5, 1);
      check_output("t7_no_fresh_pre", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    apply_stimulus(8'h00, 8'h00, 2);
    exp_q.push_back(8'h5A);
    apply_stimulus(8'h5A, 8'hA5, 3);
    check_output("t7_recapture", 1'b1, 1'b0, 1'b0, 8'd0);
    apply_stimulus(8'h00, 8'h00, 1);
    check("t7_accepted", 32'(out_valid), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
